// File: rtl/slow_to_fast_clk_signal.sv
// Moves a slow-domain event onto clk_fast: synchronizer chain, consecutive-sample
// glitch filter, then a one-shot FSM issuing one fixed-width pulse per event.
module slow_to_fast_clk_signal #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 1,
   parameter int PULSE_CYCLES  = 1,
   parameter int CNT_W         = 8
) (
   input  logic             clk_fast,
   input  logic             reset,
   input  logic             signal_in,
   output logic             signal_out,
   output logic             busy,
   output logic [CNT_W-1:0] event_count
);

   localparam int FILT_W  = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
   localparam int PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [FILT_W-1:0]  FILT_LAST  = FILT_W'(FILTER_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   sync;

   state_t                 state_q;
   logic [FILT_W-1:0]      filt_cnt_q;
   logic [PULSE_W-1:0]     pulse_cnt_q;
   logic                   signal_out_q;
   logic [CNT_W-1:0]       event_count_q;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
   assign sync   = sync_q[SYNC_STAGES-1];

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_fast or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   always_ff @(posedge clk_fast or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         filt_cnt_q    <= '0;
         pulse_cnt_q   <= '0;
         signal_out_q  <= 1'b0;
         event_count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!sync) begin
                  filt_cnt_q <= '0;
               end else if (filt_cnt_q == FILT_LAST) begin
                  state_q       <= PULSE;
                  filt_cnt_q    <= '0;
                  pulse_cnt_q   <= '0;
                  signal_out_q  <= 1'b1;
                  event_count_q <= event_count_q + CNT_W'(1);
               end else begin
                  filt_cnt_q <= filt_cnt_q + FILT_W'(1);
               end
            end
            // Input is deliberately ignored here so a short source cannot shorten the pulse.
            PULSE: begin
               if (pulse_cnt_q == PULSE_LAST) begin
                  state_q      <= WAIT_LOW;
                  signal_out_q <= 1'b0;
               end else begin
                  pulse_cnt_q <= pulse_cnt_q + PULSE_W'(1);
               end
            end
            WAIT_LOW: begin
               if (sync) begin
                  filt_cnt_q <= '0;
               end else if (filt_cnt_q == FILT_LAST) begin
                  state_q    <= IDLE;
                  filt_cnt_q <= '0;
               end else begin
                  filt_cnt_q <= filt_cnt_q + FILT_W'(1);
               end
            end
            default: begin
               state_q      <= IDLE;
               filt_cnt_q   <= '0;
               signal_out_q <= 1'b0;
            end
         endcase
      end
   end

   assign signal_out  = signal_out_q;
   assign busy        = (state_q != IDLE);
   assign event_count = event_count_q;

endmodule

// File: tb/tb_slow_to_fast_clk_signal.sv
// Drives five differently-parameterised instances with one stimulus stream and
// compares each against a window-based reference model every cycle.
module tb_slow_to_fast_clk_signal;

   localparam int NC = 5;
   localparam int S_P [NC] = '{2, 2, 2, 2, 3};
   localparam int F_P [NC] = '{1, 3, 1, 1, 2};
   localparam int P_P [NC] = '{1, 1, 4, 1, 3};
   localparam int W_P [NC] = '{8, 8, 8, 2, 4};
   localparam int MAXE = 16384;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic signal_in = 1'b0;

   logic [NC-1:0] out_w;
   logic [NC-1:0] busy_w;
   int            cnt_w [NC];

   for (genvar g = 0; g < NC; g++) begin : g_dut
      logic [W_P[g]-1:0] cnt;
      logic              o;
      logic              b;
      slow_to_fast_clk_signal #(
         .SYNC_STAGES  (S_P[g]),
         .FILTER_CYCLES(F_P[g]),
         .PULSE_CYCLES (P_P[g]),
         .CNT_W        (W_P[g])
      ) u_dut (
         .clk_fast   (clk),
         .reset      (reset),
         .signal_in  (signal_in),
         .signal_out (o),
         .busy       (b),
         .event_count(cnt)
      );
      assign out_w[g]  = o;
      assign busy_w[g] = b;
      assign cnt_w[g]  = int'(cnt);
   end

   initial forever #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Phases: 0 armed, 1 firing, 2 disarmed. A phase change happens when the
   // last F synced samples, all taken inside the current phase, agree.
   int edge_n = 0;
   int rst_edge = 0;
   bit in_hist [MAXE];
   int phase [NC];
   int phase_start [NC];
   int fire_edge [NC];
   int mcount [NC];
   bit mout [NC];

   function automatic bit sync_at(input int s, input int e);
      if (e - s >= rst_edge && e - s >= 0 && e - s < MAXE) return in_hist[e-s];
      return 1'b0;
   endfunction

   function automatic bit window(input int c, input int e, input bit val);
      if (e - F_P[c] + 1 < phase_start[c]) return 1'b0;
      for (int k = e - F_P[c] + 1; k <= e; k++)
         if (sync_at(S_P[c], k) != val) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      edge_n++;
      if (edge_n < MAXE) in_hist[edge_n] = signal_in;
      if (reset) begin
         rst_edge = edge_n + 1;
         for (int c = 0; c < NC; c++) begin
            phase[c] = 0; phase_start[c] = rst_edge; mout[c] = 1'b0; mcount[c] = 0;
         end
      end else begin
         for (int c = 0; c < NC; c++) begin
            case (phase[c])
               0: if (window(c, edge_n, 1'b1)) begin
                     phase[c] = 1; mout[c] = 1'b1; mcount[c]++; fire_edge[c] = edge_n;
                  end
               1: if (edge_n == fire_edge[c] + P_P[c]) begin
                     phase[c] = 2; mout[c] = 1'b0; phase_start[c] = edge_n + 1;
                  end
               default: if (window(c, edge_n, 1'b0)) begin
                     phase[c] = 0; phase_start[c] = edge_n + 1;
                  end
            endcase
         end
      end
   end

   // ---------------- checking ----------------
   int total = 0;
   int bad = 0;
   int pulses [NC];
   int hi_cyc [NC];
   bit prev_out [NC];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_model();
      for (int c = 0; c < NC; c++) begin
         int mask;
         mask = (1 << W_P[c]) - 1;
         check($sformatf("out[%0d]@%0d", c, edge_n), int'(out_w[c]), int'(mout[c] & !reset));
         check($sformatf("busy[%0d]@%0d", c, edge_n), int'(busy_w[c]), int'((phase[c] != 0) && !reset));
         check($sformatf("cnt[%0d]@%0d", c, edge_n), cnt_w[c], reset ? 0 : (mcount[c] & mask));
      end
   endtask

   task automatic step(input bit r, input bit v);
      reset = r;
      signal_in = v;
      @(negedge clk);
      check_model();
      for (int c = 0; c < NC; c++) begin
         if (out_w[c] && !prev_out[c]) pulses[c]++;
         if (out_w[c]) hi_cyc[c]++;
         prev_out[c] = out_w[c];
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < NC; c++) begin
         pulses[c] = 0; hi_cyc[c] = 0; prev_out[c] = out_w[c];
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      clear_stats();
   endtask

   task automatic run(input bit v, input int n);
      for (int i = 0; i < n; i++) step(1'b0, v);
   endtask

   typedef struct {
      bit rst;
      bit sin;
      bit eout;
      bit ebusy;
      int ecnt;
   } vec_t;

   vec_t tv [27];
   int   exp6 [5] = '{1, 2, 3, 0, 1};

   initial begin
      bit seen;
      int hold;
      bit v;

      // Default instance: reset, one low, twenty high, five low.
      tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
      tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
      for (int h = 0; h < 20; h++)
         tv[2+h] = '{1'b0, 1'b1, (h == 2), (h >= 2), (h >= 2) ? 1 : 0};
      for (int l = 0; l < 5; l++)
         tv[22+l] = '{1'b0, 1'b0, 1'b0, (l < 2), 1};

      @(negedge clk);
      clear_stats();

      for (int i = 0; i < 27; i++) begin
         step(tv[i].rst, tv[i].sin);
         check($sformatf("t1_out[%0d]", i), int'(out_w[0]), int'(tv[i].eout));
         check($sformatf("t1_busy[%0d]", i), int'(busy_w[0]), int'(tv[i].ebusy));
         check($sformatf("t1_cnt[%0d]", i), cnt_w[0], tv[i].ecnt);
      end

      // Two-sample glitch against a three-sample filter.
      do_reset();
      run(1'b0, 3); run(1'b1, 2); run(1'b0, 8);
      check("t2_pulses", pulses[1], 0);
      check("t2_cnt", cnt_w[1], 0);
      check("t2_busy", int'(busy_w[1]), 0);

      // Short input, four-cycle pulse.
      do_reset();
      run(1'b0, 2); run(1'b1, 2); run(1'b0, 10);
      check("t3_pulses", pulses[2], 1);
      check("t3_width", hi_cyc[2], 4);
      check("t3_cnt", cnt_w[2], 1);

      // Five spaced events, then two events only two cycles apart.
      do_reset();
      run(1'b0, 2);
      for (int e = 0; e < 5; e++) begin run(1'b1, 2); run(1'b0, 6); end
      check("t4_pulses", pulses[0], 5);
      check("t4_cnt", cnt_w[0], 5);
      clear_stats();
      run(1'b1, 1); run(1'b0, 1); run(1'b1, 1); run(1'b0, 8);
      check("t4_merge_pulses", pulses[0], 1);
      check("t4_merge_cnt", cnt_w[0], 6);

      // Reset in the second cycle of a four-cycle pulse, input held through release.
      do_reset();
      run(1'b0, 2);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1);
         if (out_w[2]) begin seen = 1'b1; break; end
      end
      check("t5_pulse_start", int'(seen), 1);
      step(1'b0, 1'b1);
      check("t5_second_cycle", int'(out_w[2]), 1);
      reset = 1'b1;
      #1;
      check("t5_out_drop", int'(out_w[2]), 0);
      check("t5_cnt_clear", cnt_w[2], 0);
      check("t5_busy_clear", int'(busy_w[2]), 0);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      clear_stats();
      run(1'b1, 15);
      check("t5_new_pulses", pulses[2], 1);
      check("t5_new_width", hi_cyc[2], 4);
      check("t5_new_cnt", cnt_w[2], 1);
      check("t5_default_pulses", pulses[0], 1);

      // Two-bit counter wrap.
      do_reset();
      run(1'b0, 2);
      for (int e = 0; e < 5; e++) begin
         run(1'b1, 2); run(1'b0, 6);
         check($sformatf("t6_cnt[%0d]", e), cnt_w[3], exp6[e]);
      end

      // Random holds with occasional resets; the model checks every cycle.
      do_reset();
      hold = 0;
      v = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (hold == 0) begin
            v = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
         end
         hold--;
         step(($urandom_range(0, 199) == 0), v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
